// File: rtl/ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifetch_unit : RV64 instruction-fetch stage, single outstanding imem request |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module ifetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [XLEN-1:0] r_pend_pc, w_pend_pc_nxt;
    logic [31:0]     r_pend_inst, w_pend_inst_nxt;
    logic            r_if_valid, w_if_valid_nxt;
    logic [XLEN-1:0] r_if_pc, w_if_pc_nxt;
    logic [31:0]     r_if_inst, w_if_inst_nxt;
    logic            w_handshake;

    // Gated by rst so no request is ever presented while reset is asserted.
    assign imem_req_valid = rst && (r_state == ST_REQ);
    assign imem_req_addr  = r_pc;
    assign w_handshake    = imem_req_valid && imem_req_ready;

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_REQ;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= '0;
            r_pend_pc   <= '0;
            r_pend_inst <= '0;
            r_if_valid  <= 1'b0;
            r_if_pc     <= '0;
            r_if_inst   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_pend_pc   <= w_pend_pc_nxt;
            r_pend_inst <= w_pend_inst_nxt;
            r_if_valid  <= w_if_valid_nxt;
            r_if_pc     <= w_if_pc_nxt;
            r_if_inst   <= w_if_inst_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_pend_pc_nxt   = r_pend_pc;
        w_pend_inst_nxt = r_pend_inst;
        w_if_valid_nxt  = r_if_valid;
        w_if_pc_nxt     = r_if_pc;
        w_if_inst_nxt   = r_if_inst;

        // ID consumes the current instruction; a fill below may replace it.
        if (r_if_valid && !stall) begin
            w_if_valid_nxt = 1'b0;
        end

        case (r_state)
            ST_REQ: begin
                if (w_handshake) begin
                    w_fetch_pc_nxt = r_pc;
                    w_pc_nxt       = r_pc + c_pc_step;
                    w_state_nxt    = redirect_valid ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    w_state_nxt = ST_REQ;
                    if (!redirect_valid) begin
                        if (!r_if_valid || !stall) begin
                            w_if_valid_nxt = 1'b1;
                            w_if_pc_nxt    = r_fetch_pc;
                            w_if_inst_nxt  = imem_resp_data;
                        end else begin
                            w_pend_pc_nxt   = r_fetch_pc;
                            w_pend_inst_nxt = imem_resp_data;
                            w_state_nxt     = ST_HOLD;
                        end
                    end
                end else if (redirect_valid) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_state_nxt = ST_REQ;
                end else if (!stall) begin
                    w_if_valid_nxt = 1'b1;
                    w_if_pc_nxt    = r_pend_pc;
                    w_if_inst_nxt  = r_pend_inst;
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_resp_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase

        // A redirect overrides every other event, including a held output.
        if (redirect_valid) begin
            w_pc_nxt       = redirect_pc;
            w_if_valid_nxt = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ifetch_unit : randomized scoreboard bench for ifetch_unit                |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_ifetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    ifetch_unit #(.XLEN(64), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_delivered = 0;

    // Expected program-order stream seen by ID; reloaded on every redirect/reset.
    logic [63:0] exp_q[$];

    // Memory model state (driver side) and handshake info (monitor side).
    logic        mem_busy = 1'b0;
    logic [63:0] mem_addr = '0;
    int          mem_cnt  = 0;
    logic        hs_flag  = 1'b0;
    logic [63:0] hs_addr  = '0;
    logic        fast_mode = 1'b0;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void reload(input logic [63:0] pc);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(pc + 64'(4 * i));
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        prev_rst = 1'b0;
    logic        prev_redirect = 1'b0;
    logic        prev_if_valid = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_req_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [63:0] prev_if_pc = '0;
    logic [31:0] prev_if_inst = '0;
    logic [63:0] prev_req_addr = '0;
    logic [63:0] prev_rpc = '0;
    logic [63:0] exp_fetch = RESET_PC;
    logic [63:0] hs_a = '0;
    logic [63:0] mon_e;
    logic        mon_hs;
    int          cyc = 0;
    int          hs_cyc = -10;
    int          fast_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        fast_cnt = (fast_mode && rst === 1'b1) ? fast_cnt + 1 : 0;
        if (prev_rst === 1'b0) begin
            chk("reset_if_valid", if_valid === 1'b0, 64'(if_valid), 64'd0);
            chk("reset_if_pc", if_pc === 64'd0, if_pc, 64'd0);
            chk("reset_if_inst", if_inst === 32'd0, 64'(if_inst), 64'd0);
        end else begin
            if (prev_redirect) begin
                chk("redirect_clears_valid", if_valid === 1'b0, 64'(if_valid), 64'd0);
            end else if (prev_if_valid && prev_stall) begin
                chk("stall_hold", if_valid === 1'b1 && if_pc === prev_if_pc && if_inst === prev_if_inst,
                    if_pc, prev_if_pc);
            end
            if (prev_req_valid && !prev_ready && rst === 1'b1) begin
                if (prev_redirect)
                    chk("redirect_addr_no_hs", imem_req_valid === 1'b1 && imem_req_addr === prev_rpc,
                        imem_req_addr, prev_rpc);
                else
                    chk("req_addr_stable", imem_req_valid === 1'b1 && imem_req_addr === prev_req_addr,
                        imem_req_addr, prev_req_addr);
            end
        end

        mon_hs = 1'b0;
        if (rst !== 1'b1) begin
            chk("req_valid_in_reset", imem_req_valid === 1'b0, 64'(imem_req_valid), 64'd0);
            exp_fetch = RESET_PC;
        end else begin
            mon_hs = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
            if (fast_cnt >= 3 && cyc == hs_cyc + 2)
                chk("fast_latency", if_valid === 1'b1 && if_pc === hs_a && mon_hs, if_pc, hs_a);
            if (mon_hs) begin
                chk("one_outstanding", !mem_busy, 64'(mem_busy), 64'd0);
                chk("fetch_addr", imem_req_addr === exp_fetch, imem_req_addr, exp_fetch);
                exp_fetch = redirect_valid ? redirect_pc : imem_req_addr + 64'd4;
                hs_cyc = cyc;
                hs_a = imem_req_addr;
            end else if (redirect_valid) begin
                exp_fetch = redirect_pc;
            end
            if (if_valid === 1'b1 && !stall && !redirect_valid) begin
                n_delivered++;
                if (exp_q.size() == 0) begin
                    chk("stream_nonempty", 1'b0 != 1'b0, if_pc, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("if_pc", if_pc === mon_e, if_pc, mon_e);
                    chk("if_inst", if_inst === mon_e[31:0], 64'(if_inst), 64'(mon_e[31:0]));
                end
            end
        end
        hs_flag = mon_hs;
        hs_addr = imem_req_addr;

        prev_rst       = rst;
        prev_redirect  = redirect_valid;
        prev_if_valid  = if_valid;
        prev_stall     = stall;
        prev_req_valid = imem_req_valid;
        prev_ready     = imem_req_ready;
        prev_if_pc     = if_pc;
        prev_if_inst   = if_inst;
        prev_req_addr  = imem_req_addr;
        prev_rpc       = redirect_pc;
    end

    // ---------------- driver + memory model ----------------
    // rmode: 0 none, 1 always, 2 right after a handshake, 3 same cycle as a handshake
    task automatic step(input logic rdy, input logic stl, input int rmode, input logic [63:0] rpc,
                        input int lat, input logic rst_v, input logic fast);
        logic rdv;
        @(posedge clk);
        #1;
        if (rst === 1'b0) begin
            mem_busy = 1'b0;
            mem_cnt  = 0;
        end else begin
            if (imem_resp_valid) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (hs_flag) begin
                mem_busy = 1'b1;
                mem_addr = hs_addr;
                mem_cnt  = lat;
            end
        end
        imem_resp_valid = mem_busy && (mem_cnt == 1);
        imem_resp_data  = imem_resp_valid ? mem_addr[31:0] : $urandom;
        case (rmode)
            1:       rdv = 1'b1;
            2:       rdv = hs_flag;
            3:       rdv = (imem_req_valid === 1'b1) && rdy;
            default: rdv = 1'b0;
        endcase
        rdv = rdv && rst_v;
        rst            = rst_v;
        imem_req_ready = rdy;
        stall          = stl;
        redirect_valid = rdv;
        redirect_pc    = rdv ? rpc : {$urandom, $urandom};
        fast_mode      = fast;
        if (!rst_v) reload(RESET_PC);
        else if (rdv) reload(rpc);
    endtask

    task automatic fast_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 64'd0, 1, 1'b1, 1'b1);
    endtask

    task automatic redirect_on(input string name, input int rmode, input logic [63:0] rpc, input int lat);
        logic hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step(1'b1, 1'b0, rmode, rpc, lat, 1'b1, 1'b0);
            hit = redirect_valid;
        end
        chk(name, hit, 64'(hit), 64'd1);
    endtask

    logic        got;
    logic [63:0] rpc_r;

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        reload(RESET_PC);
        repeat (3) step(1'b0, 1'b0, 0, 64'd0, 1, 1'b0, 1'b0);

        fast_steps(20);
        redirect_on("redirect_in_wait_issued", 2, 64'h0000_0000_8000_1000, 2);
        fast_steps(12);
        redirect_on("redirect_with_hs_issued", 3, 64'h0000_0000_8000_1800, 1);
        fast_steps(12);

        repeat (4) step(1'b1, 1'b1, 0, 64'd0, 1, 1'b1, 1'b0);
        fast_steps(10);

        repeat (8) step(1'b1, 1'b1, 0, 64'd0, 1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1, 64'h0000_0000_8000_3000, 1, 1'b1, 1'b0);
        fast_steps(10);

        repeat (5) step(1'b0, 1'b0, 0, 64'd0, 1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1, 64'h0000_0000_8000_2000, 1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 64'd0, 1, 1'b1, 1'b0);
        fast_steps(10);

        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1, 1'b0, 0, 64'd0, 2, 1'b1, 1'b0);
            got = mem_busy && !imem_resp_valid;
        end
        chk("reset_mid_wait_reached", got, 64'(got), 64'd1);
        repeat (2) step(1'b1, 1'b0, 0, 64'd0, 1, 1'b0, 1'b0);
        fast_steps(10);

        step(1'b1, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1'b1, 1'b0);
        fast_steps(10);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom % 3)
                0:       rpc_r = 64'h0000_0000_8000_0000 + 64'(($urandom % 1024) * 4);
                1:       rpc_r = 64'hFFFF_FFFF_FFFF_FFF0;
                default: rpc_r = 64'h0000_0000_8000_0102;
            endcase
            step(($urandom % 4) != 0, ($urandom % 3) == 0, (($urandom % 16) == 0) ? 1 : 0,
                 rpc_r, 1 + int'($urandom % 3), ($urandom % 400) >= 2, 1'b0);
        end
        fast_steps(10);

        chk("min_deliveries", n_delivered > 200, 64'(n_delivered), 64'd200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV64 pipeline. It consumes the branch/jump redirect that the execute stage produces (branch-taken flag plus target PC) and owns the PC register.
- It issues one-at-a-time requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- It presents {valid, pc, inst} to the IF/ID boundary. It honours the hazard-unit stall and squashes wrong-path fetches on redirect.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000: first fetch address after reset.
- XLEN, 64: PC and address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge).
- redirect_valid  in  1  EX branch taken or jump; one-cycle pulse.
- redirect_pc  in  XLEN  target PC; used only when redirect_valid=1.
- stall  in  1  ID cannot accept; hold the IF/ID outputs.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  fetch address.
- imem_resp_valid  in  1  response data valid; one pulse per accepted request, in order.
- imem_resp_data  in  32  instruction word.
- if_valid  out  1  if_pc/if_inst hold a live instruction.
- if_pc  out  XLEN  PC of if_inst.
- if_inst  out  32  instruction word.

Behaviour:
- Registers:
  - pc_reg: next address to fetch.
  - fetch_pc: address of the outstanding request.
  - pend_pc, pend_inst: skid buffer.
  - Output registers if_valid, if_pc, if_inst.
  - State machine with states REQ, WAIT, HOLD, DROP.
- Reset:
  - state=REQ, pc_reg=RESET_PC, if_valid=0, if_pc=0, if_inst=0.
  - imem_req_valid is combinational and equals 1 in REQ only, so it is 0 while rst=0 and 1 in the first cycle after release.
  - Reset asserted mid-operation abandons any outstanding response. The memory side is reset by the same rst.
- imem_req_addr = pc_reg. It is stable while in REQ unless a redirect occurs.
- Redirect has priority over every other event in every state:
  - if_valid<=0 next cycle, regardless of stall.
  - pc_reg<=redirect_pc, stored unmodified; no alignment check.
- REQ:
  - Handshake (valid&ready) with no redirect: fetch_pc<=pc_reg, pc_reg<=pc_reg+4 (wraps mod 2^64), go to WAIT.
  - Handshake and redirect in the same cycle: the request for the old PC is issued; go to DROP with pc_reg=redirect_pc.
  - Redirect without handshake: stay in REQ; the new address is presented next cycle.
- WAIT, on imem_resp_valid:
  - With redirect: discard the response, go to REQ.
  - Output slot free (if_valid==0 or stall==0): if_valid<=1, if_pc<=fetch_pc, if_inst<=data, go to REQ.
  - Otherwise: capture the response into pend_pc/pend_inst, go to HOLD.
  - Redirect without a response: go to DROP.
- HOLD:
  - When stall==0: move pend into the output registers (if_valid<=1), go to REQ.
  - Redirect: discard pend, go to REQ.
- DROP:
  - Wait for imem_resp_valid, discard it, go to REQ.
  - A redirect arriving in DROP updates pc_reg and stays in DROP.
  - A response and a redirect in the same cycle: discard the response, go to REQ with the new pc_reg.
- Output consumption: if_valid & !stall with no new fill that cycle gives if_valid<=0. With stall=1 and no redirect, if_pc/if_inst/if_valid hold.
- Throughput and latency:
  - At most one outstanding request.
  - With a 1-cycle-latency, always-ready memory the block delivers one instruction every 2 cycles.
  - First if_valid appears 2 cycles after the first handshake.
- imem_resp_valid outside WAIT/DROP is a protocol violation; behaviour is unspecified and assertion-checked in the bench.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning addr[31:0] as data: req_addr 0x80000000, 0x80000004, 0x80000008 on alternate cycles; if_pc/if_inst follow with if_valid pulses.
- Redirect to 0x80001000 during WAIT (response arrives next cycle): response for 0x80000004 dropped, never visible; next req_addr=0x80001000; if_valid=0 for the dropped slot.
- Redirect in the same cycle as a REQ handshake: DROP entered, one response swallowed, then req_addr=redirect_pc.
- stall=1 for 4 cycles while a second response arrives: first instruction held unchanged; second goes to HOLD; after stall drops, second appears next cycle; no loss or duplication.
- Redirect while in HOLD with stall=1: if_valid cleared despite stall, pending discarded, fetch restarts at redirect_pc.
- imem_req_ready=0 for 3 cycles then redirect to 0x80002000: req_addr switches without a handshake; the first accepted request uses 0x80002000; assert rst=0 mid-WAIT gives all outputs at reset values and req_addr=RESET_PC after release.
